// File: rtl/reg_file_wb.sv
// Architectural register file for the RV32I single-cycle core: write-back capture into rd,
// three independent combinational read ports, a registered a0 mirror and a commit counter.
module reg_file_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 0,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic                  x0_wr_seen
);
  localparam int NREG   = 2**ADDR_WIDTH;
  localparam int NPORTS = 3;

  logic [NREG-1:0][DATA_WIDTH-1:0]   regs_q, regs_d;
  logic [DATA_WIDTH-1:0]             a0_q, a0_d;
  logic [CNT_WIDTH-1:0]              wr_count_q, wr_count_d;
  logic                              x0_wr_seen_q, x0_wr_seen_d;
  logic                              we;
  logic [NPORTS-1:0][ADDR_WIDTH-1:0] raddr;
  logic [NPORTS-1:0][DATA_WIDTH-1:0] rdata;

  // x0 writes are legal no-ops; only non-zero destinations commit.
  assign we = reg_write && (rd_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[rd_addr] = result;
    regs_d[0]    = '0;
    wr_count_d   = we ? wr_count_q + CNT_WIDTH'(1) : wr_count_q;
    a0_d         = (we && rd_addr == ADDR_WIDTH'(10)) ? result : a0_q;
    x0_wr_seen_d = x0_wr_seen_q | (reg_write && rd_addr == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q       <= '0;
      a0_q         <= '0;
      wr_count_q   <= '0;
      x0_wr_seen_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      a0_q         <= a0_d;
      wr_count_q   <= wr_count_d;
      x0_wr_seen_q <= x0_wr_seen_d;
    end
  end

  assign raddr = {dbg_addr, rs2_addr, rs1_addr};

  // Forwarding only matters for committing writes, so x0 still reads zero with BYPASS=1.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      rdata[p] = regs_q[raddr[p]];
      if (BYPASS != 0 && we && raddr[p] == rd_addr) rdata[p] = result;
      if (!rst_n) rdata[p] = '0;
    end
  end

  assign rd1        = rdata[0];
  assign rd2        = rdata[1];
  assign dbg_data   = rdata[2];
  assign a0         = a0_q;
  assign wr_count   = wr_count_q;
  assign x0_wr_seen = x0_wr_seen_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: three instances (default, BYPASS=1, CNT_WIDTH=4) share one stimulus;
// expectations are queued as stimulus is driven and popped when outputs are sampled.
module tb_reg_file_wb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd_addr = '0, rs1_addr = '0, rs2_addr = '0, dbg_addr = '0;
  logic [31:0] result = '0;

  logic [31:0] rd1, rd2, dbg, a0, wrc;
  logic        x0s;
  logic [31:0] rd1_b, rd2_b, dbg_b, a0_b, wrc_b;
  logic        x0s_b;
  logic [31:0] rd1_c, rd2_c, dbg_c, a0_c;
  logic [3:0]  wrc_c;
  logic        x0s_c;

  typedef struct { string nm; logic [31:0] v; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl [32];
  int          cnt;

  always #5 clk = ~clk;

  reg_file_wb dut (.clk(clk), .rst_n(rst_n), .reg_write(reg_write), .rd_addr(rd_addr),
    .result(result), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd1(rd1), .rd2(rd2),
    .dbg_addr(dbg_addr), .dbg_data(dbg), .a0(a0), .wr_count(wrc), .x0_wr_seen(x0s));

  reg_file_wb #(.BYPASS(1)) dut_b (.clk(clk), .rst_n(rst_n), .reg_write(reg_write),
    .rd_addr(rd_addr), .result(result), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1(rd1_b), .rd2(rd2_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b), .a0(a0_b),
    .wr_count(wrc_b), .x0_wr_seen(x0s_b));

  reg_file_wb #(.CNT_WIDTH(4)) dut_c (.clk(clk), .rst_n(rst_n), .reg_write(reg_write),
    .rd_addr(rd_addr), .result(result), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1(rd1_c), .rd2(rd2_c), .dbg_addr(dbg_addr), .dbg_data(dbg_c), .a0(a0_c),
    .wr_count(wrc_c), .x0_wr_seen(x0s_c));

  always @(posedge clk)
    if (rst_n) assert (!$isunknown(reg_write)) else $error("reg_write is X/Z");

  task automatic wr(input logic [4:0] rd, input logic [31:0] val);
    reg_write = 1'b1; rd_addr = rd; result = val;
    @(posedge clk); #1;
    reg_write = 1'b0;
  endtask

  task automatic do_reset();
    reg_write = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd10, 32'hA5A5A5A5);
    wr(5'd0, 32'h1);
    rs1_addr = 5'd5; dbg_addr = 5'd10; #1;
    sb.push_back('{"pre_rst_x5", 32'hDEADBEEF});
    e = sb.pop_front(); checks++;
    if (rd1 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1, e.v); end
    // Mid-cycle assertion of reset: clock is high here.
    rst_n = 1'b0;
    sb.push_back('{"rst_rd1", 32'h0}); sb.push_back('{"rst_wrc", 32'h0});
    sb.push_back('{"rst_a0", 32'h0});  sb.push_back('{"rst_x0seen", 32'h0});
    sb.push_back('{"rst_dbg", 32'h0});
    #1;
    e = sb.pop_front(); checks++;
    if (rd1 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1, e.v); end
    e = sb.pop_front(); checks++;
    if (wrc !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, wrc, e.v); end
    e = sb.pop_front(); checks++;
    if (a0 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, a0, e.v); end
    e = sb.pop_front(); checks++;
    if ({31'd0, x0s} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, x0s, e.v); end
    e = sb.pop_front(); checks++;
    if (dbg !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, dbg, e.v); end
    // Writes during reset are ignored, and bypass must not leak result either.
    reg_write = 1'b1; rd_addr = 5'd5; result = 32'h77;
    sb.push_back('{"rst_bypass_rd1", 32'h0}); sb.push_back('{"rst_wr_ignored", 32'h0});
    #1;
    e = sb.pop_front(); checks++;
    if (rd1_b !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1_b, e.v); end
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (wrc !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, wrc, e.v); end
    reg_write = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
  endtask

  task automatic test_basic_write();
    rs1_addr = 5'd7; dbg_addr = 5'd7;
    wr(5'd7, 32'h12345678); cnt++;
    sb.push_back('{"basic_rd1", 32'h12345678}); sb.push_back('{"basic_dbg", 32'h12345678});
    sb.push_back('{"basic_wrc", 32'(cnt)});     sb.push_back('{"basic_a0", 32'h0});
    e = sb.pop_front(); checks++;
    if (rd1 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1, e.v); end
    e = sb.pop_front(); checks++;
    if (dbg !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, dbg, e.v); end
    e = sb.pop_front(); checks++;
    if (wrc !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, wrc, e.v); end
    e = sb.pop_front(); checks++;
    if (a0 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, a0, e.v); end
  endtask

  task automatic test_x0_guard();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    reg_write = 1'b1; rd_addr = 5'd0; result = 32'hFFFFFFFF; #1;
    sb.push_back('{"x0_bypass_rd1", 32'h0});
    e = sb.pop_front(); checks++;
    if (rd1_b !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1_b, e.v); end
    @(posedge clk); #1; reg_write = 1'b0;
    sb.push_back('{"x0_rd1", 32'h0}); sb.push_back('{"x0_wrc", 32'(cnt)});
    sb.push_back('{"x0_seen", 32'h1});
    e = sb.pop_front(); checks++;
    if (rd1 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1, e.v); end
    e = sb.pop_front(); checks++;
    if (wrc !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, wrc, e.v); end
    e = sb.pop_front(); checks++;
    if ({31'd0, x0s} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, x0s, e.v); end
  endtask

  task automatic test_read_during_write();
    wr(5'd3, 32'h11); cnt++;
    rs1_addr = 5'd3; rs2_addr = 5'd3; dbg_addr = 5'd3;
    reg_write = 1'b1; rd_addr = 5'd3; result = 32'h22; #1;
    sb.push_back('{"rdw_rd1_pre", 32'h11});   sb.push_back('{"rdw_rd2_pre", 32'h11});
    sb.push_back('{"rdw_b_rd1_pre", 32'h22}); sb.push_back('{"rdw_b_rd2_pre", 32'h22});
    sb.push_back('{"rdw_b_dbg_pre", 32'h22});
    e = sb.pop_front(); checks++;
    if (rd1 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1, e.v); end
    e = sb.pop_front(); checks++;
    if (rd2 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd2, e.v); end
    e = sb.pop_front(); checks++;
    if (rd1_b !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1_b, e.v); end
    e = sb.pop_front(); checks++;
    if (rd2_b !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd2_b, e.v); end
    e = sb.pop_front(); checks++;
    if (dbg_b !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, dbg_b, e.v); end
    @(posedge clk); #1; reg_write = 1'b0; cnt++;
    sb.push_back('{"rdw_rd1_post", 32'h22}); sb.push_back('{"rdw_rd2_post", 32'h22});
    e = sb.pop_front(); checks++;
    if (rd1 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1, e.v); end
    e = sb.pop_front(); checks++;
    if (rd2 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd2, e.v); end
  endtask

  task automatic test_a0_tracking();
    wr(5'd10, 32'h55); cnt++;
    sb.push_back('{"a0_after_x10", 32'h55});
    e = sb.pop_front(); checks++;
    if (a0 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, a0, e.v); end
    rs2_addr = 5'd11;
    wr(5'd11, 32'h99); cnt++;
    sb.push_back('{"a0_after_x11", 32'h55}); sb.push_back('{"x11_rd2", 32'h99});
    sb.push_back('{"a0_wrc", 32'(cnt)});
    e = sb.pop_front(); checks++;
    if (a0 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, a0, e.v); end
    e = sb.pop_front(); checks++;
    if (rd2 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd2, e.v); end
    e = sb.pop_front(); checks++;
    if (wrc !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, wrc, e.v); end
  endtask

  task automatic test_no_write();
    rs1_addr = 5'd7;
    reg_write = 1'b0; rd_addr = 5'd7; result = 32'hCAFEF00D;
    @(posedge clk); #1;
    sb.push_back('{"nowr_rd1", 32'h12345678}); sb.push_back('{"nowr_wrc", 32'(cnt)});
    e = sb.pop_front(); checks++;
    if (rd1 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1, e.v); end
    e = sb.pop_front(); checks++;
    if (wrc !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, wrc, e.v); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    rs1_addr = 5'd1;
    for (int i = 0; i < 17; i++) wr(5'd1, 32'(i + 100));
    sb.push_back('{"wrap_c_wrc", 32'd1}); sb.push_back('{"wrap_wide_wrc", 32'd17});
    sb.push_back('{"wrap_x1", 32'd116});
    e = sb.pop_front(); checks++;
    if ({28'd0, wrc_c} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, wrc_c, e.v); end
    e = sb.pop_front(); checks++;
    if (wrc !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, wrc, e.v); end
    e = sb.pop_front(); checks++;
    if (rd1_c !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1_c, e.v); end
    rd_addr = 5'd1; result = 32'hBAD;
    for (int i = 0; i < 17; i++) begin @(posedge clk); #1; end
    sb.push_back('{"wrap_idle_wrc", 32'd1}); sb.push_back('{"wrap_idle_x1", 32'd116});
    e = sb.pop_front(); checks++;
    if ({28'd0, wrc_c} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, wrc_c, e.v); end
    e = sb.pop_front(); checks++;
    if (rd1_c !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1_c, e.v); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rd;
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      rd = 5'($urandom_range(0, 31)); v = $urandom;
      reg_write = 1'b1; rd_addr = rd; result = v;
      if (rd != 5'd0) begin mdl[rd] = v; cnt++; end
      @(posedge clk); #1;
    end
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); rs1_addr = 5'(31 - i);
      sb.push_back('{$sformatf("b2b_dbg_x%0d", i), mdl[i]});
      sb.push_back('{$sformatf("b2b_rd1_x%0d", 31 - i), mdl[31 - i]});
      #1;
      e = sb.pop_front(); checks++;
      if (dbg !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, dbg, e.v); end
      e = sb.pop_front(); checks++;
      if (rd1 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, rd1, e.v); end
    end
    sb.push_back('{"b2b_a0", mdl[10]}); sb.push_back('{"b2b_wrc", 32'(cnt)});
    e = sb.pop_front(); checks++;
    if (a0 !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, a0, e.v); end
    e = sb.pop_front(); checks++;
    if (wrc !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.nm, wrc, e.v); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic_write();
    test_x0_guard();
    test_read_during_write();
    test_a0_tracking();
    test_no_write();
    test_counter_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
